mipi_csi2_tx: RTL and testbench
===============================

# mipi_csi2_tx

Two-lane MIPI CSI-2 packet transmitter: the transmit-side counterpart of the camera receive path. It accepts a RAW8 pixel stream plus frame-start and frame-end requests from the video pipeline, and emits complete CSI-2 packets as one byte per lane per clock. Each packet carries an HS-zero preamble, the 0xB8 sync byte, a header with ECC, the payload, and a CRC followed by a trailer. Output bytes feed an external DDR serializer on the byte clock; bits go out LSB first.

## Interface
- pVC, 0: virtual channel, bits [7:6] of DI.
- pLINE_BYTES, 640: RAW8 payload bytes per line. Must be even and ≥2.
- pHS_ZERO, 4: number of preamble cycles with both lanes at 0x00.
- pTRAIL, 2: number of trailer cycles.
- pGAP, 8: LP gap cycles between packets.
- iCLK  in  1  byte clock (single clock domain).
- iRESET  in  1  synchronous reset, active-high.
- iFS  in  1  frame-start request pulse.
- iFE  in  1  frame-end request pulse.
- iDATA  in  16  two pixels per beat: [7:0] goes to lane 0, [15:8] to lane 1.
- iVALID  in  1  pixel beat valid.
- oREADY  out  1  beat accepted when iVALID&oREADY.
- oLANE0, oLANE1  out  8  lane bytes.
- oHS_EN  out  1  lanes in HS mode.
- oBUSY  out  1  state≠IDLE.
- oUNDERRUN  out  1  one-cycle pulse on a payload cycle without iVALID.

## Operation
- States: IDLE → HS_ZERO → SYNC → HDR0 → HDR1 → {PAYLOAD → CRC} or (short packet) → TRAIL → GAP → IDLE.
- Request latching:
  - iFS and iFE set pending flags in any state; repeated pulses merge into one.
  - A line request is iVALID high while in IDLE. It is not latched; the beat stays unaccepted.
- IDLE priority: pending FS, then line, then pending FE. A pending flag clears on entry to HS_ZERO.
- Lane contents per state:
  - HS_ZERO: both lanes 0x00.
  - SYNC: both lanes 0xB8.
  - HDR0: lane0 = DI, lane1 = WC[7:0].
  - HDR1: lane0 = WC[15:8], lane1 = ECC.
- DI values: FS {pVC,6'h00}; FE {pVC,6'h01}; line {pVC,6'h2A}. WC is 0 for short packets and pLINE_BYTES for lines.
- ECC: CSI-2 6-bit Hamming code over {WC,DI} (DI in bits [7:0]); ECC[7:6] = 0.
- PAYLOAD:
  - Lasts pLINE_BYTES/2 cycles, with oREADY high only in PAYLOAD.
  - Each accepted beat appears on the lanes on the next cycle.
  - Underrun: a PAYLOAD cycle with no iVALID sends 0x00 on both lanes, pulses oUNDERRUN, and still counts the cycle. CSI-2 HS cannot stall.
- CRC:
  - CRC-16, reflected poly 0x8408, init 0xFFFF, no final XOR.
  - Input bytes in wire order: lane0 byte, then lane1 byte, each beat.
  - CRC state: lane0 = CRC[7:0], lane1 = CRC[15:8].
- TRAIL: for pTRAIL cycles, each lane sends 0xFF if bit 7 of its last HS byte was 0, else 0x00.
- GAP: oHS_EN = 0 and lanes 0x00 for pGAP cycles.
- oHS_EN is 1 from HS_ZERO through TRAIL inclusive.
- Reset values: state IDLE, all outputs 0, pending flags clear, CRC = 0xFFFF, counters 0.
- iRESET mid-packet abandons the packet. On the next cycle oHS_EN = 0 and lanes = 0; no trailer is sent.

## Timing
- All outputs are registered.
- Line request seen in IDLE at cycle 0: HS_ZERO occupies cycles 1..pHS_ZERO, then SYNC, HDR0, HDR1.
- oREADY rises in the cycle before the first PAYLOAD lane cycle, so beat k accepted at cycle t is on the lanes at t+1.
- Line packet length: pHS_ZERO + 3 + pLINE_BYTES/2 + 1 + pTRAIL HS cycles, followed by pGAP LP cycles.
- Short packet length: pHS_ZERO + 3 + pTRAIL HS cycles, followed by pGAP LP cycles.
- iFS/iFE arriving in the same cycle as IDLE exit are latched and serviced after the following GAP.

## Configuration
- MIPI_TX_CRC_EN defined: CRC computed as in Operation.
- MIPI_TX_CRC_EN undefined: the CRC cycle sends 0x0000 ("checksum not computed") and the CRC logic is removed.

## Structure
- Package mipi_tx_pkg holds:
  - DT constants (FS 0x00, FE 0x01, RAW8 0x2A) and the 0xB8 sync constant.
  - The state enum.
  - An ECC function.
  - A 2-byte-per-cycle CRC step function.
- Sub-module mipi_crc16: accumulator with clear/enable, 16-bit input, 16-bit output. Instantiated only under MIPI_TX_CRC_EN.

## Test plan
- iFS pulse with default params → HS cycles: 4×{00,00}, {B8,B8}, {00,00}, {00,00}, then the trailer; oHS_EN high for 9 cycles, then 8 low.
- iFE pulse → header lane0/lane1: {01,00}, {00,07}.
- ECC function unit check: DI 0x37, WC 0x01F0 → ECC 0x3F.
- pLINE_BYTES=24 and payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → CRC cycle lanes {F0,00}. With MIPI_TX_CRC_EN undefined → {00,00}.
- iVALID dropped for 2 cycles mid-line → 2 oUNDERRUN pulses, {00,00} on those cycles, packet length unchanged.
- iFS and iFE in the same cycle while busy → FS packet, GAP, then FE packet. iRESET asserted in PAYLOAD → oHS_EN 0 next cycle, oBUSY 0.

Source files
------------

// File: rtl/mipi_tx_pkg.sv
// mipi_tx_pkg: CSI-2 transmit constants, FSM state type, header ECC and two-byte CRC step.
package mipi_tx_pkg;

    localparam logic [5:0] DT_FS     = 6'h00;
    localparam logic [5:0] DT_FE     = 6'h01;
    localparam logic [5:0] DT_RAW8   = 6'h2A;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HS_ZERO,
        ST_SYNC,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CRC,
        ST_TRAIL,
        ST_GAP
    } state_e;

    // Each parity bit is the XOR of the header bits selected by its mask; D = {WC, DI}.
    function automatic logic [7:0] calc_ecc(input logic [7:0] di, input logic [15:0] wc);
        logic [23:0] d;
        d = {wc, di};
        return {2'b00,
                ^(d & 24'hEFFC00),
                ^(d & 24'hDF03F0),
                ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D),
                ^(d & 24'hF2555B),
                ^(d & 24'hF12CB7)};
    endfunction

    // Bit-serial reflected CRC-16 (0x8408): lane0 byte first, LSB first, then lane1 byte.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 16; i++)
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/mipi_crc16.sv
// mipi_crc16: CRC-16 accumulator over one 16-bit lane beat per enabled cycle.
module mipi_crc16
    import mipi_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) crc_q <= 16'hFFFF;
        else if (en_i)      crc_q <= crc16_step(crc_q, data_i);
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/mipi_csi2_tx.sv
// mipi_csi2_tx: two-lane CSI-2 packet transmitter (FS/FE short packets, RAW8 lines).
// Define MIPI_TX_CRC_EN to compute the payload CRC; otherwise the CRC cycle sends 0x0000.
module mipi_csi2_tx
    import mipi_tx_pkg::*;
#(
    parameter logic [1:0] pVC         = 2'd0,
    parameter int         pLINE_BYTES = 640,
    parameter int         pHS_ZERO    = 4,
    parameter int         pTRAIL      = 2,
    parameter int         pGAP        = 8
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iFS,
    input  logic        iFE,
    input  logic [15:0] iDATA,
    input  logic        iVALID,
    output logic        oREADY,
    output logic [7:0]  oLANE0,
    output logic [7:0]  oLANE1,
    output logic        oHS_EN,
    output logic        oBUSY,
    output logic        oUNDERRUN
);

    localparam logic [15:0] HZ_END  = 16'(pHS_ZERO - 1);
    localparam logic [15:0] PL_END  = 16'(pLINE_BYTES / 2 - 1);
    localparam logic [15:0] TR_END  = 16'(pTRAIL - 1);
    localparam logic [15:0] GP_END  = 16'(pGAP - 1);
    localparam logic [15:0] WC_LINE = 16'(pLINE_BYTES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fs_q, fs_d, fe_q, fe_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [7:0]  lane0_q, lane0_d, lane1_q, lane1_d;
    logic        hs_q, hs_d, busy_q, busy_d, rdy_q, rdy_d, und_q, und_d;
    logic [15:0] beat, crc;

    // HS cannot stall: a missing beat goes out as zeros and still consumes its slot.
    assign beat = (rdy_q && iVALID) ? iDATA : 16'h0000;

    always_comb begin
        state_d = state_q;
        fs_d    = fs_q | iFS;
        fe_d    = fe_q | iFE;
        di_d    = di_q;
        wc_d    = wc_q;
        case (state_q)
            ST_IDLE: if (fs_q || iVALID || fe_q) begin
                state_d = ST_HS_ZERO;
                di_d    = {pVC, fs_q ? DT_FS : iVALID ? DT_RAW8 : DT_FE};
                wc_d    = (!fs_q && iVALID) ? WC_LINE : 16'h0000;
                fs_d    = iFS;
                fe_d    = iFE | (fe_q & (fs_q | iVALID));
            end
            ST_HS_ZERO: state_d = (cnt_q == HZ_END) ? ST_SYNC : ST_HS_ZERO;
            ST_SYNC:    state_d = ST_HDR0;
            ST_HDR0:    state_d = ST_HDR1;
            ST_HDR1:    state_d = (wc_q != 16'h0000) ? ST_PAYLOAD : ST_TRAIL;
            ST_PAYLOAD: state_d = (cnt_q == PL_END) ? ST_CRC : ST_PAYLOAD;
            ST_CRC:     state_d = ST_TRAIL;
            ST_TRAIL:   state_d = (cnt_q == TR_END) ? ST_GAP : ST_TRAIL;
            ST_GAP:     state_d = (cnt_q == GP_END) ? ST_IDLE : ST_GAP;
            default:    state_d = ST_IDLE;
        endcase
        cnt_d = (state_d == state_q) ? cnt_q + 16'd1 : 16'd0;
        // Outputs are registered from the next state so they line up with state_q.
        lane0_d = 8'h00;
        lane1_d = 8'h00;
        case (state_d)
            ST_SYNC: begin
                lane0_d = SYNC_BYTE;
                lane1_d = SYNC_BYTE;
            end
            ST_HDR0: begin
                lane0_d = di_q;
                lane1_d = wc_q[7:0];
            end
            ST_HDR1: begin
                lane0_d = wc_q[15:8];
                lane1_d = calc_ecc(di_q, wc_q);
            end
            ST_PAYLOAD: begin
                lane0_d = beat[7:0];
                lane1_d = beat[15:8];
            end
            ST_CRC: begin
                lane0_d = crc[7:0];
                lane1_d = crc[15:8];
            end
            ST_TRAIL: begin
                lane0_d = (state_q == ST_TRAIL) ? lane0_q : {8{~lane0_q[7]}};
                lane1_d = (state_q == ST_TRAIL) ? lane1_q : {8{~lane1_q[7]}};
            end
            default: begin
                lane0_d = 8'h00;
                lane1_d = 8'h00;
            end
        endcase
        hs_d   = (state_d != ST_IDLE) && (state_d != ST_GAP);
        busy_d = state_d != ST_IDLE;
        // Ready leads the payload lane slot by one cycle.
        rdy_d  = ((state_d == ST_HDR1) && (wc_q != 16'h0000)) ||
                 ((state_d == ST_PAYLOAD) && (cnt_d != PL_END));
        und_d  = (state_d == ST_PAYLOAD) && !iVALID;
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            di_q    <= 8'h00;
            wc_q    <= 16'h0000;
            lane0_q <= 8'h00;
            lane1_q <= 8'h00;
            hs_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            di_q    <= di_d;
            wc_q    <= wc_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            hs_q    <= hs_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            und_q   <= und_d;
        end
    end

`ifdef MIPI_TX_CRC_EN
    mipi_crc16 u_crc (
        .clk_i  (iCLK),
        .rst_i  (iRESET),
        .clr_i  (state_d == ST_HS_ZERO),
        .en_i   (state_d == ST_PAYLOAD),
        .data_i (beat),
        .crc_o  (crc)
    );
`else
    assign crc = 16'h0000;
`endif

    assign oREADY    = rdy_q;
    assign oLANE0    = lane0_q;
    assign oLANE1    = lane1_q;
    assign oHS_EN    = hs_q;
    assign oBUSY     = busy_q;
    assign oUNDERRUN = und_q;

endmodule

// File: tb/tb_mipi_csi2_tx.sv
// tb_mipi_csi2_tx: directed vectors for short packets, RAW8 lines, underrun, request merging and reset.
module tb_mipi_csi2_tx;
    import mipi_tx_pkg::*;

    localparam int HALF = 12;

    logic        iCLK = 1'b0, iRESET = 1'b1, iFS = 1'b0, iFE = 1'b0, iVALID = 1'b0;
    logic [15:0] iDATA = 16'h0000;
    logic        oREADY, oHS_EN, oBUSY, oUNDERRUN;
    logic [7:0]  oLANE0, oLANE1;

    mipi_csi2_tx #(.pLINE_BYTES(24)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iFS(iFS), .iFE(iFE), .iDATA(iDATA), .iVALID(iVALID),
        .oREADY(oREADY), .oLANE0(oLANE0), .oLANE1(oLANE1), .oHS_EN(oHS_EN),
        .oBUSY(oBUSY), .oUNDERRUN(oUNDERRUN)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic       fs, fe;
        logic [7:0] l0, l1;
        logic       hs, busy;
    } vec_t;

    vec_t        tbl[$];
    int          n_chk = 0, n_fail = 0;
    int          und_n, gap_n;
    logic [7:0]  c0[$], c1[$];
    logic [7:0]  pay[24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                             8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                             8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
`ifdef MIPI_TX_CRC_EN
    logic [15:0] exp_crc = 16'hF000;
    logic [31:0] exp_trl = 32'h00FF00FF;
`else
    logic [15:0] exp_crc = 16'h0000;
    logic [31:0] exp_trl = 32'hFFFFFFFF;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic add(input logic fs, input logic fe, input logic [7:0] l0, input logic [7:0] l1,
                       input logic hs, input logic busy);
        vec_t v;
        v.fs = fs; v.fe = fe; v.l0 = l0; v.l1 = l1; v.hs = hs; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic add_short(input logic fs, input logic fe, input logic [7:0] di, input logic [7:0] ecc);
        add(fs, fe, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (4) add(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'hB8, 8'hB8, 1'b1, 1'b1);
        add(1'b0, 1'b0, di, 8'h00, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, ecc, 1'b1, 1'b1);
        repeat (2) add(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        repeat (8) add(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // Streams one line; ready cycles drop_at and drop_at+1 are left without iVALID.
    task automatic run_line(input int drop_at);
        int   k, rc, c;
        logic r, seen;
        c0.delete(); c1.delete();
        und_n = 0; gap_n = 0; k = 0; rc = 0; seen = 1'b0;
        iVALID = 1'b1;
        iDATA  = {pay[1], pay[0]};
        for (c = 0; c < 100; c++) begin
            r = oREADY;
            tick();
            if (r) begin
                if (iVALID) k++;
                rc++;
            end
            if (oHS_EN) begin
                c0.push_back(oLANE0);
                c1.push_back(oLANE1);
            end else if (oBUSY) gap_n++;
            if (oUNDERRUN) und_n++;
            if (oBUSY) seen = 1'b1;
            else if (seen) break;
            iVALID = (rc < HALF) && (rc != drop_at) && (rc != drop_at + 1);
            if (k < HALF) iDATA = {pay[2*k+1], pay[2*k]};
        end
        check("line_done", c < 100, 1'b1);
        check("line_hs_len", c0.size(), 22);
        check("line_gap_len", gap_n, 8);
    endtask

    initial begin
        logic [7:0] dis[$];
        logic       prev_hs;
        int         idx, hs_tot;

        repeat (3) tick();
        check("reset_outputs", {oLANE0, oLANE1, oHS_EN, oBUSY, oREADY, oUNDERRUN}, 0);
        iRESET = 1'b0;

        check("ecc_fn", calc_ecc(8'h37, 16'h01F0), 8'h3F);

        add_short(1'b1, 1'b0, 8'h00, 8'h00);
        add_short(1'b0, 1'b1, 8'h01, 8'h07);
        for (int i = 0; i < tbl.size(); i++) begin
            iFS = tbl[i].fs;
            iFE = tbl[i].fe;
            tick();
            check($sformatf("short_row%0d", i),
                  {oLANE0, oLANE1, oHS_EN, oBUSY, oREADY, oUNDERRUN},
                  {tbl[i].l0, tbl[i].l1, tbl[i].hs, tbl[i].busy, 2'b00});
        end
        iFS = 1'b0;
        iFE = 1'b0;

        run_line(99);
        check("line_hdr0", {c0[5], c1[5]}, 16'h2A18);
        check("line_hdr1", {c0[6], c1[6]}, 16'h0013);
        for (int j = 0; j < HALF; j++)
            check($sformatf("line_pay%0d", j), {c0[7+j], c1[7+j]}, {pay[2*j], pay[2*j+1]});
        check("line_crc", {c0[19], c1[19]}, exp_crc);
        check("line_trail", {c0[20], c1[20], c0[21], c1[21]}, exp_trl);
        check("line_no_underrun", und_n, 0);

        run_line(5);
        check("urun_pulses", und_n, 2);
        for (int j = 0; j < HALF; j++)
            check($sformatf("urun_pay%0d", j), {c0[7+j], c1[7+j]},
                  j < 5 ? {pay[2*j], pay[2*j+1]} : j < 7 ? 16'h0000 : {pay[2*j-4], pay[2*j-3]});

        prev_hs = 1'b0; idx = 0; hs_tot = 0;
        for (int c = 0; c < 120; c++) begin
            iFS = (c == 0) || (c == 3);
            iFE = (c == 3) || (c == 5);
            tick();
            if (oHS_EN) begin
                idx = prev_hs ? idx + 1 : 0;
                if (idx == 5) dis.push_back(oLANE0);
                hs_tot++;
            end
            prev_hs = oHS_EN;
        end
        iFS = 1'b0;
        iFE = 1'b0;
        check("merge_packets", dis.size(), 3);
        check("merge_order", {dis[0], dis[1], dis[2]}, 24'h000001);
        check("merge_hs_total", hs_tot, 27);
        check("merge_idle", oBUSY, 1'b0);

        iVALID = 1'b1;
        iDATA  = {pay[1], pay[0]};
        for (int c = 0; c < 30 && !oREADY; c++) tick();
        check("rst_reached_payload", oREADY, 1'b1);
        repeat (3) tick();
        check("rst_in_payload", {oHS_EN, oBUSY}, 2'b11);
        iRESET = 1'b1;
        iVALID = 1'b0;
        tick();
        check("rst_abandon", {oLANE0, oLANE1, oHS_EN, oBUSY, oREADY, oUNDERRUN}, 0);
        iRESET = 1'b0;
        repeat (3) tick();
        check("rst_stays_idle", {oHS_EN, oBUSY}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
